// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the sequence generator: FSM encoding, program codes,
// value range and the last value of each program before it restarts.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PROG_UP   = 3'd0,
        PROG_DOWN = 3'd1,
        PROG_EVEN = 3'd2,
        PROG_ODD  = 3'd3,
        PROG_FIB  = 3'd4,
        PROG_POW2 = 3'd5,
        PROG_SQR  = 3'd6,
        PROG_TRI  = 3'd7
    } prog_t;

    localparam logic [15:0] MAX_VAL       = 16'd9999;
    localparam logic [15:0] FIB_LAST      = 16'd6765;
    localparam logic [15:0] POW_LAST      = 16'd8192;
    localparam logic [15:0] SQR_LAST      = 16'd9801;
    localparam logic [15:0] TRI_LAST      = 16'd9870;
    // Fibonacci keeps (cur, prev); starting from (0, 1) yields 0, 1, 1, 2, 3, ...
    localparam logic [15:0] FIB_PREV_INIT = 16'd1;

    function automatic logic [15:0] prog_init(input prog_t p);
        case (p)
            PROG_DOWN: prog_init = MAX_VAL;
            PROG_ODD:  prog_init = 16'd1;
            PROG_POW2: prog_init = 16'd1;
            default:   prog_init = 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] prog_last(input prog_t p);
        case (p)
            PROG_UP:   prog_last = MAX_VAL;
            PROG_DOWN: prog_last = 16'd0;
            PROG_EVEN: prog_last = 16'd9998;
            PROG_ODD:  prog_last = MAX_VAL;
            PROG_FIB:  prog_last = FIB_LAST;
            PROG_POW2: prog_last = POW_LAST;
            PROG_SQR:  prog_last = SQR_LAST;
            default:   prog_last = TRI_LAST;
        endcase
    endfunction

endpackage

// File: rtl/seq_gen_tick.sv
// Prescaler: one-cycle tick every (DIV << modulo) enabled cycles; holds its count while disabled.
// Tick is combinational from the count register; i_clr has priority over i_en.
module tick_gen #(
    parameter int DIV = 25_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic [1:0] i_modulo,
    output logic       o_tick
);
    localparam int CW = $clog2(DIV * 8 + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_lim;

    assign w_lim  = CW'((DIV << i_modulo) - 1);
    assign o_tick = i_en && (r_cnt == w_lim);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Programmable sequence generator: IDLE/RUN/PAUSE control, one value step per prescaler tick.
// New value and wrap appear the cycle after the tick; start/stop/clear are single-cycle pulses.
module seq_gen
    import seq_pkg::*;
#(
    parameter int DIV = 25_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_clear,
    input  logic [2:0]  i_prog_sel,
    input  logic [1:0]  i_mod_sel,
    output logic [2:0]  o_prog,
    output logic [1:0]  o_modulo,
    output logic [15:0] o_data_2,
    output logic        o_busy,
    output logic        o_wrap
);
    state_t      r_state;
    state_t      w_nxt_state;
    prog_t       r_prog;
    logic [1:0]  r_mod;
    logic [15:0] r_data;
    logic [15:0] r_prev;
    logic [15:0] r_n;
    logic        r_wrap;

    logic        w_busy;
    logic        w_run;
    logic        w_load;
    logic        w_tick;
    logic [16:0] w_sum;
    logic        w_restart;
    logic [15:0] w_nxt_data;
    logic [15:0] w_nxt_prev;
    logic [15:0] w_nxt_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_nxt_state = ST_RUN;
            ST_RUN:   if (i_stop)  w_nxt_state = ST_PAUSE;
            ST_PAUSE: if (i_start) w_nxt_state = ST_RUN;
            default:               w_nxt_state = ST_IDLE;
        endcase
        if (i_clear) w_nxt_state = ST_IDLE;
    end

    always_comb begin
        w_busy = (r_state == ST_RUN) || (r_state == ST_PAUSE);
        w_run  = (r_state == ST_RUN);
        w_load = (r_state == ST_IDLE) && i_start && !i_clear;
    end

    tick_gen #(.DIV(DIV)) u_tick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (w_run),
        .i_clr    (w_load || i_clear),
        .i_modulo (r_mod),
        .o_tick   (w_tick)
    );

    // 17-bit sums so the range compare sees the true value, including 0-1 on the down count.
    always_comb begin
        w_sum      = {1'b0, r_data};
        w_nxt_prev = r_prev;
        w_nxt_n    = r_n;
        case (r_prog)
            PROG_UP:   w_sum = {1'b0, r_data} + 17'd1;
            PROG_DOWN: w_sum = {1'b0, r_data} - 17'd1;
            PROG_EVEN: w_sum = {1'b0, r_data} + 17'd2;
            PROG_ODD:  w_sum = {1'b0, r_data} + 17'd2;
            PROG_FIB: begin
                w_sum      = {1'b0, r_data} + {1'b0, r_prev};
                w_nxt_prev = r_data;
            end
            PROG_POW2: w_sum = {r_data, 1'b0};
            PROG_SQR: begin
                w_sum   = {1'b0, r_data} + {r_n, 1'b0} + 17'd1;
                w_nxt_n = r_n + 16'd1;
            end
            PROG_TRI: begin
                w_sum   = {1'b0, r_data} + {1'b0, r_n} + 17'd1;
                w_nxt_n = r_n + 16'd1;
            end
            default: ;
        endcase
        w_restart  = (w_sum > {1'b0, MAX_VAL}) || (r_data == prog_last(r_prog));
        w_nxt_data = w_sum[15:0];
        if (w_restart) begin
            w_nxt_data = prog_init(r_prog);
            w_nxt_prev = FIB_PREV_INIT;
            w_nxt_n    = 16'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prog <= PROG_UP;
            r_mod  <= 2'd0;
            r_data <= 16'd0;
            r_prev <= 16'd0;
            r_n    <= 16'd0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_load) begin
                r_prog <= prog_t'(i_prog_sel);
                r_mod  <= i_mod_sel;
                r_data <= prog_init(prog_t'(i_prog_sel));
                r_prev <= FIB_PREV_INIT;
                r_n    <= 16'd0;
            end else if (w_tick && !i_clear) begin
                r_data <= w_nxt_data;
                r_prev <= w_nxt_prev;
                r_n    <= w_nxt_n;
                r_wrap <= w_restart;
            end
        end
    end

    assign o_prog   = r_prog;
    assign o_modulo = r_mod;
    assign o_data_2 = r_data;
    assign o_busy   = w_busy;
    assign o_wrap   = r_wrap;

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter DIV, default 25_000_000: base prescaler count in clk cycles; tick period = DIV << modulo.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle pulse; begin from IDLE or resume from PAUSE.
REQ-005 stop  input  1  single-cycle pulse; pause a running sequence.
REQ-006 clear  input  1  single-cycle pulse; abort to IDLE.
REQ-007 prog_sel  input  3  requested program code.
REQ-008 mod_sel  input  2  requested speed code.
REQ-009 prog  output  3  latched program, for the display stage.
REQ-010 modulo  output  2  latched speed, for the display stage.
REQ-011 data_2  output  16  current sequence value, always 0..9999.
REQ-012 busy  output  1  high in RUN or PAUSE.
REQ-013 wrap  output  1  one-cycle pulse when the sequence restarts.

Function
REQ-014 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-015 Transitions: IDLE+start->RUN; RUN+stop->PAUSE; PAUSE+start->RUN; any state+clear->IDLE.
REQ-016 Priority: clear > stop > start; start and stop in the same cycle in RUN -> PAUSE.
REQ-017 IDLE->RUN: latch prog_sel->prog and mod_sel->modulo, load the program initial value into data_2, clear the prescaler; prog_sel/mod_sel are ignored outside IDLE.
REQ-018 Prescaler: counts only in RUN and holds in PAUSE; tick asserts for one cycle when count reaches (DIV<<modulo)-1, then count returns to 0.
REQ-019 data_2 SHALL advance exactly once per tick, registered, with the new value visible the cycle after the tick.
REQ-020 Programs (initial value; step; restart when next value >9999 or sequence end):
- 0 up: 0; +1; 9999->0.
- 1 down: 9999; -1; 0->9999.
- 2 even: 0; +2; 9998->0.
- 3 odd: 1; +2; 9999->1.
- 4 Fibonacci: 0; next = cur+prev; restart to 0,1,... after 6765 (10946 >9999).
- 5 powers of two: 1; x2; 8192->1.
- 6 squares: 0; +(2n+1); 9801->0.
- 7 triangular: 0; +n; 9870->0.
REQ-021 Auxiliary state (prev, n) SHALL reinitialise on every restart and on IDLE->RUN.
REQ-022 wrap SHALL pulse in the same cycle data_2 takes the restart value; it does not pulse on the initial load.
REQ-023 Internal sums SHALL be at least 17 bits wide so the >9999 compare is exact with no overflow.
REQ-024 IDLE: data_2 holds its last value; busy=0.
REQ-025 clear in the same cycle as a tick: the tick is discarded and data_2 is unchanged.

Reset
REQ-026 rst low: state=IDLE, prescaler=0, prog=0, modulo=0, data_2=0, busy=0, wrap=0, auxiliary registers=0, all immediately and asynchronously.
REQ-027 Reset asserted mid-RUN: sequence is abandoned; after release the block waits in IDLE for start.

Structure
REQ-028 Shared package seq_pkg SHALL hold the state encoding, the eight program codes, MAX_VAL=9999 and the Fibonacci/power/square/triangular restart thresholds.
REQ-029 The prescaler SHALL be a sub-module tick_gen(clk, rst, en, clr, modulo, tick) with parameter DIV.

Verification (DIV=4, so a tick occurs every 4 cycles at modulo 0)
REQ-030 prog_sel=0, mod_sel=0, start -> data_2 = 0,1,2,3 on successive ticks 4 cycles apart; busy=1.
REQ-031 prog_sel=1, start -> data_2 = 9999 then 9998; force through 0 -> next value 9999 with wrap=1 for one cycle.
REQ-032 prog_sel=4, run 21 ticks -> 0,1,1,2,3,5,...,6765, then 0 with wrap, then 1.
REQ-033 mod_sel=3, start -> ticks every 32 cycles; change prog_sel mid-run -> prog and the sequence are unaffected.
REQ-034 stop at value 5, wait 100 cycles, start -> data_2 stays 5 during PAUSE, then 6 after the remaining prescaler count; start and stop in the same cycle -> PAUSE.
REQ-035 rst low mid-RUN -> all outputs zero asynchronously; clear coincident with a tick -> IDLE with data_2 unchanged.
